// File: rtl/relu_execution.sv
// ReLU execution stage: streams tiles from a source buffer, applies element-wise ReLU and writes them to a destination buffer.
// Optional output saturation at CLAMP_MAX is enabled by defining RELU_CLAMP_EN.
module relu_execution #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TILE_WIDTH = 256,
  parameter int unsigned TILE_ELEMS = TILE_WIDTH / DATA_WIDTH,
  parameter int          CLAMP_MAX  = 127
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4:0]            src_buffer_id,
  input  logic [4:0]            dest_buffer_id,
  input  logic [9:0]            length,
  output logic                  done,
  output logic                  vec_read_enable,
  output logic [4:0]            vec_read_buffer_id,
  input  logic [TILE_WIDTH-1:0] vec_read_tile,
  input  logic                  vec_read_valid,
  output logic                  vec_write_enable,
  output logic [4:0]            vec_write_buffer_id,
  output logic [TILE_WIDTH-1:0] vec_write_tile
);

  localparam int unsigned CNT_W = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_REQ,
    S_WAIT_READ,
    S_WRITE,
    S_COMPLETE
  } state_t;

  state_t                state_q;
  logic [4:0]            src_id_q;
  logic [4:0]            dest_id_q;
  logic [9:0]            length_q;
  logic [CNT_W-1:0]      total_tiles_q;
  logic [CNT_W-1:0]      tile_count_q;
  logic                  rd_en_q;
  logic                  wr_en_q;
  logic                  done_q;
  logic [TILE_WIDTH-1:0] wr_tile_q;
  logic [TILE_WIDTH-1:0] wr_tile_d;
  logic [CNT_W-1:0]      elem_base;

`ifdef RELU_CLAMP_EN
  localparam logic signed [DATA_WIDTH-1:0] CLAMP_V = DATA_WIDTH'(CLAMP_MAX);
`endif

  function automatic logic [DATA_WIDTH-1:0] relu_lane(input logic [DATA_WIDTH-1:0] x);
    if (x[DATA_WIDTH-1]) return '0;
`ifdef RELU_CLAMP_EN
    if ($signed(x) > CLAMP_V) return CLAMP_V;
`endif
    return x;
  endfunction

  assign elem_base = CNT_W'(tile_count_q * TILE_ELEMS);

  // Lanes past the end of the vector are zeroed so the tail tile never leaks stale data.
  always_comb begin
    wr_tile_d = '0;
    for (int unsigned i = 0; i < TILE_ELEMS; i++) begin
      if ((elem_base + CNT_W'(i)) < {1'b0, length_q}) begin
        wr_tile_d[i*DATA_WIDTH +: DATA_WIDTH] = relu_lane(vec_read_tile[i*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      src_id_q      <= '0;
      dest_id_q     <= '0;
      length_q      <= '0;
      total_tiles_q <= '0;
      tile_count_q  <= '0;
      rd_en_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      done_q        <= 1'b0;
      wr_tile_q     <= '0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            src_id_q      <= src_buffer_id;
            dest_id_q     <= dest_buffer_id;
            length_q      <= length;
            total_tiles_q <= CNT_W'((32'(length) + TILE_ELEMS - 1) / TILE_ELEMS);
            tile_count_q  <= '0;
            if (length == '0) begin
              state_q <= S_COMPLETE;
            end else begin
              rd_en_q <= 1'b1;
              state_q <= S_READ_REQ;
            end
          end
        end
        S_READ_REQ: begin
          state_q <= S_WAIT_READ;
        end
        S_WAIT_READ: begin
          if (vec_read_valid) begin
            wr_tile_q <= wr_tile_d;
            wr_en_q   <= 1'b1;
            state_q   <= S_WRITE;
          end
        end
        S_WRITE: begin
          tile_count_q <= tile_count_q + CNT_W'(1);
          if ((tile_count_q + CNT_W'(1)) >= total_tiles_q) begin
            done_q  <= 1'b1;
            state_q <= S_COMPLETE;
          end else begin
            rd_en_q <= 1'b1;
            state_q <= S_READ_REQ;
          end
        end
        S_COMPLETE: begin
          // Arriving from WRITE, done is already high; the zero-length path raises it here instead.
          if (done_q) begin
            state_q <= S_IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done                = done_q;
  assign vec_read_enable     = rd_en_q;
  assign vec_read_buffer_id  = src_id_q;
  assign vec_write_enable    = wr_en_q;
  assign vec_write_buffer_id = dest_id_q;
  assign vec_write_tile      = wr_tile_q;

endmodule

// File: tb/tb_relu_execution.sv
// Testbench for relu_execution: table vectors, randomized tiles against an element-wise reference, and reset/noise sequences.
module tb_relu_execution;

  localparam int CM = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   src_buffer_id = '0;
  logic [4:0]   dest_buffer_id = '0;
  logic [9:0]   length = '0;
  logic         done;
  logic         vec_read_enable;
  logic [4:0]   vec_read_buffer_id;
  logic [255:0] vec_read_tile = '0;
  logic         vec_read_valid = 1'b0;
  logic         vec_write_enable;
  logic [4:0]   vec_write_buffer_id;
  logic [255:0] vec_write_tile;

  relu_execution #(.DATA_WIDTH(8), .TILE_WIDTH(256), .CLAMP_MAX(CM)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .src_buffer_id       (src_buffer_id),
    .dest_buffer_id      (dest_buffer_id),
    .length              (length),
    .done                (done),
    .vec_read_enable     (vec_read_enable),
    .vec_read_buffer_id  (vec_read_buffer_id),
    .vec_read_tile       (vec_read_tile),
    .vec_read_valid      (vec_read_valid),
    .vec_write_enable    (vec_write_enable),
    .vec_write_buffer_id (vec_write_buffer_id),
    .vec_write_tile      (vec_write_tile)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [255:0] src_mem [0:31];
  logic [255:0] wr_got  [0:31];

  typedef struct {
    int           len;
    logic [255:0] tin;
    logic [255:0] texp;
  } vec_t;
  vec_t tbl [4];

  task automatic chk_i(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_t(input string name, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: element g of the vector becomes max(x,0) (optionally min'd with CM), or 0 past the length.
  function automatic logic [255:0] model_tile(input logic [255:0] x, input int len, input int j);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      int v;
      v = int'($signed(x[i*8 +: 8]));
      if ((j * 32 + i) < len && v > 0) begin
`ifdef RELU_CLAMP_EN
        if (v > CM) v = CM;
`endif
        r[i*8 +: 8] = 8'(v);
      end
    end
    return r;
  endfunction

  task automatic fill_random(input int n);
    for (int j = 0; j < n; j++)
      for (int w = 0; w < 8; w++)
        src_mem[j][w*32 +: 32] = $urandom();
  endtask

  // Acts as the buffer controller for one operation and checks every handshake event.
  task automatic run_op(input int len, input int lat, input logic [4:0] sid, input logic [4:0] did, input bit noise);
    int exp_tiles, n_rd, n_wr, n_done, due, rd_cyc, last_wr, done_cyc, budget;
    exp_tiles = (len + 31) / 32;
    n_rd = 0; n_wr = 0; n_done = 0; due = -1; rd_cyc = 0; last_wr = 0; done_cyc = -1;
    budget = exp_tiles * (lat + 2) + 12;
    start = 1'b1; src_buffer_id = sid; dest_buffer_id = did; length = 10'(len);
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      start = 1'b0; vec_read_valid = 1'b0; vec_read_tile = '0;
      if (k == due) begin
        vec_read_valid = 1'b1;
        vec_read_tile  = src_mem[(n_rd - 1) % 32];
        due = -1;
      end
      if (vec_read_enable) begin
        n_rd++;
        chk_i("rd_id", int'(vec_read_buffer_id), int'(sid));
        chk_i("rd_cycle", k, (n_rd == 1) ? 1 : last_wr + 1);
        rd_cyc = k;
        due = k + lat;
        if (noise) begin
          vec_read_valid = 1'b1; vec_read_tile = '1;
          start = 1'b1; length = 10'd5; src_buffer_id = 5'd31; dest_buffer_id = 5'd31;
        end
      end
      if (vec_write_enable) begin
        n_wr++;
        chk_i("wr_id", int'(vec_write_buffer_id), int'(did));
        chk_i("wr_cycle", k, rd_cyc + lat + 1);
        chk_t("wr_tile", vec_write_tile, model_tile(src_mem[(n_wr - 1) % 32], len, n_wr - 1));
        wr_got[(n_wr - 1) % 32] = vec_write_tile;
        last_wr = k;
        if (noise) begin
          start = 1'b1; length = 10'd5;
        end
      end
      if (done) begin
        n_done++;
        done_cyc = k;
      end
      if (done_cyc >= 0 && k >= done_cyc + 2) break;
    end
    start = 1'b0; vec_read_valid = 1'b0;
    chk_i("num_reads", n_rd, exp_tiles);
    chk_i("num_writes", n_wr, exp_tiles);
    chk_i("num_done", n_done, 1);
    chk_i("done_cycle", done_cyc, (len == 0) ? 2 : last_wr + 1);
  endtask

  initial begin
    logic [255:0] t;
    logic [7:0] c7f, c40, c07, c64;
    int n_rd, due, ev;

`ifdef RELU_CLAMP_EN
    c7f = 8'd6; c40 = 8'd6; c07 = 8'd6; c64 = 8'd6;
`else
    c7f = 8'h7F; c40 = 8'h40; c07 = 8'h07; c64 = 8'h64;
`endif
    t = '0; t[7:0] = 8'h80; t[15:8] = 8'hFF; t[23:16] = 8'h00; t[31:24] = 8'h01; t[39:32] = 8'h7F; t[255:248] = 8'h40;
    tbl[0].len = 32; tbl[0].tin = t;
    t = '0; t[31:24] = 8'h01; t[39:32] = c7f; t[255:248] = c40;
    tbl[0].texp = t;
    t = '0; t[7:0] = 8'hFB; t[15:8] = 8'h03; t[23:16] = 8'h06; t[31:24] = 8'h07; t[39:32] = 8'h64;
    tbl[1].len = 5; tbl[1].tin = t;
    t = '0; t[15:8] = 8'h03; t[23:16] = 8'h06; t[31:24] = c07; t[39:32] = c64;
    tbl[1].texp = t;
    tbl[2].len = 3; tbl[2].tin = {32{8'h05}};
    t = '0; t[23:0] = {3{8'h05}};
    tbl[2].texp = t;
    t = {32{8'h81}}; t[247:240] = 8'h02; t[255:248] = 8'h02;
    tbl[3].len = 31; tbl[3].tin = t;
    t = '0; t[247:240] = 8'h02;
    tbl[3].texp = t;

    repeat (3) @(posedge clk);
    #1;
    chk_i("reset_rd_en", int'(vec_read_enable), 0);
    chk_i("reset_wr_en", int'(vec_write_enable), 0);
    chk_i("reset_done", int'(done), 0);
    chk_i("reset_rd_id", int'(vec_read_buffer_id), 0);
    chk_t("reset_wr_tile", vec_write_tile, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      src_mem[0] = tbl[i].tin;
      run_op(tbl[i].len, 1, 5'(i + 1), 5'(i + 2), 1'b0);
      chk_t("tbl_tile", wr_got[0], tbl[i].texp);
    end

    fill_random(3);
    run_op(70, 3, 5'd2, 5'd9, 1'b0);
    chk_t("len70_tail", 256'(wr_got[2][255:48]), '0);

    run_op(0, 1, 5'd4, 5'd5, 1'b0);

    for (int r = 0; r < 5; r++) begin
      int rl;
      logic [4:0] id;
      rl = int'($urandom_range(1, 300));
      id = 5'($urandom());
      fill_random(32);
      run_op(rl, int'($urandom_range(1, 4)), id, (r % 2 == 0) ? id : 5'($urandom()), 1'b0);
    end

    fill_random(32);
    run_op(1023, 1, 5'd30, 5'd1, 1'b0);

    fill_random(3);
    run_op(70, 2, 5'd6, 5'd6, 1'b1);

    // Abort during the second tile's read wait, then offer a stale valid.
    src_mem[0] = {32{8'h11}};
    n_rd = 0; due = -1;
    start = 1'b1; src_buffer_id = 5'd3; dest_buffer_id = 5'd4; length = 10'd96;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      start = 1'b0; vec_read_valid = 1'b0;
      if (k == due) begin
        vec_read_valid = 1'b1; vec_read_tile = src_mem[0];
      end
      if (vec_read_enable) begin
        n_rd++;
        if (n_rd == 2) break;
        due = k + 1;
      end
    end
    chk_i("rst_reach_tile1", n_rd, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_i("rst_abort_rd_en", int'(vec_read_enable), 0);
    chk_i("rst_abort_wr_en", int'(vec_write_enable), 0);
    chk_i("rst_abort_done", int'(done), 0);
    chk_i("rst_abort_rd_id", int'(vec_read_buffer_id), 0);
    chk_i("rst_abort_wr_id", int'(vec_write_buffer_id), 0);
    chk_t("rst_abort_wr_tile", vec_write_tile, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    vec_read_valid = 1'b1; vec_read_tile = {32{8'h22}};
    ev = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      vec_read_valid = 1'b0;
      if (vec_read_enable || vec_write_enable || done) ev++;
    end
    chk_i("rst_stale_events", ev, 0);
    chk_t("rst_stale_tile", vec_write_tile, '0);

    fill_random(2);
    run_op(40, 2, 5'd7, 5'd7, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
